bcd_counter_top: RTL and testbench
==================================

// Module: bcd_counter_top
// PURPOSE
//  Free-running two-digit BCD up-counter, 00..99, wrapping to 00.
//  Q[7:4] holds the tens digit and Q[3:0] holds the units digit.
//  The block is a standalone top-level counter that drives a decimal display or monitor path.
//  It has no enable or load input and counts on every clock edge outside reset.
// PARAMETERS
//  NUM_DIGITS  2  Number of cascaded BCD digits; Q width = 4*NUM_DIGITS; count range 0..10^NUM_DIGITS-1.
// PORTS
//  clk   in   1             Single clock, rising-edge active.
//  _rst  in   1             Asynchronous reset, active-HIGH (despite the underscore name).
//  Q     out  4*NUM_DIGITS  BCD count; digit k = Q[4k+3:4k]; digit 0 = units.
//  tc    out  1             Terminal count; present only with BCD_CNT_TC_EN.
// BEHAVIOUR
//  - Reset: while _rst=1, Q=0 (all digits 0) immediately, without waiting for clk.
//  - Reset is asynchronous on assertion. Deassertion is taken at the clock edge.
//  - Counting: at each posedge clk with _rst=0, Q advances by one decimal count.
//  - Reset release: the first posedge after _rst falls gives Q=01, so latency is 1 cycle.
//  - Digit rule: if digit==9 (or illegal 10..15), digit<=0 and carry to the next digit. Otherwise digit<=digit+1.
//  - Carry into digit k+1 = AND of the "digit==9" flags of all digits 0..k.
//  - Wrap: 09->10, 19->20, 99->00 in one cycle. No sticky overflow flag.
//  - Q is registered; there is no combinational path from inputs to Q.
//  - Reset mid-count forces Q=00 asynchronously. Counting resumes from 00 after release.
//  - Digits never hold values 10..15 in normal operation.
// CONFIGURATION
//  Macro BCD_CNT_TC_EN:
//  - Defined: add output tc = 1 combinationally whenever Q == all-9s (99 for 2 digits), else 0.
//    tc = 0 during reset.
//  - Undefined: no tc port; counting behaviour is identical.
// STRUCTURE
//  Package bcd_counter_pkg:
//  - typedef logic [3:0] bcd_digit_t
//  - localparam BCD_MAX = 4'd9
//  - function bcd_inc(digit, cin) returning {cout, next}
//  Sub-module bcd_digit:
//  - Ports: clk, _rst, cin, q[3:0], is_nine.
//  - One 4-bit mod-10 register that increments when cin=1.
//  Top level:
//  - Generate loop instantiates NUM_DIGITS bcd_digit instances.
//  - Digit 0 has cin=1. Digit k has cin = AND of is_nine for digits 0..k-1.
// TESTING
//  Clock period 10 ns.
//  1. Hold _rst=1 for 20 ns, then drop it -> Q=00 during reset; Q=01, 02, ... on successive posedges.
//  2. Count 10 edges from 00 -> Q sequence reaches 09 and then 10 (tens=1, units=0).
//  3. Run 99 edges from reset -> Q=99 (tc=1 if enabled); next edge -> Q=00, tc=0.
//  4. Pulse _rst=1 for 3 ns mid-cycle at Q=12 -> Q=00 immediately, before any clk edge; resumes 01 after release.
//  5. Hold _rst=1 across many edges -> Q stays 00 and tc stays 0.
//  6. Run 250 edges from reset -> Q=50; check that each digit never exceeds 9.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared types and the single-digit BCD increment rule for the cascaded BCD counter.
package bcd_counter_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Returns {carry_out, next_digit}; values 9..15 roll to 0 so an illegal digit self-heals.
  function automatic logic [DIGIT_W:0] bcd_inc(input bcd_digit_t digit, input logic cin);
    logic       cout;
    bcd_digit_t nxt;
    cout = cin && (digit >= BCD_MAX);
    if (!cin) begin
      nxt = digit;
    end else if (digit >= BCD_MAX) begin
      nxt = '0;
    end else begin
      nxt = digit + DIGIT_W'(1);
    end
    return {cout, nxt};
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One mod-10 BCD digit register; advances when cin is high, flags when it holds 9.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       _rst,
  input  logic       cin,
  output bcd_digit_t q,
  output logic       is_nine
);

  bcd_digit_t q_next;
  logic       unused_cout;

  always_comb begin
    q_next      = q;
    unused_cout = 1'b0;
    {unused_cout, q_next} = bcd_inc(q, cin);
  end

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  // Carry into higher digits is formed from these flags, not from bcd_inc's carry-out.
  assign is_nine = (q == BCD_MAX);

endmodule

// File: rtl/bcd_counter_top.sv
// Free-running cascaded BCD up-counter (00..99 by default), async active-high reset.
// Optional terminal-count output tc enabled by defining BCD_CNT_TC_EN.
module bcd_counter_top
  import bcd_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          _rst,
  output logic [DIGIT_W*NUM_DIGITS-1:0] Q
`ifdef BCD_CNT_TC_EN
  ,
  output logic                          tc
`endif
);

  logic [NUM_DIGITS-1:0] is_nine;
  // carry[k] enables digit k; carry[NUM_DIGITS] is high exactly when every digit is 9.
  logic [NUM_DIGITS:0]   carry;

  assign carry[0] = 1'b1;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      ._rst    (_rst),
      .cin     (carry[k]),
      .q       (Q[DIGIT_W*k +: DIGIT_W]),
      .is_nine (is_nine[k])
    );
    assign carry[k+1] = carry[k] & is_nine[k];
  end

`ifdef BCD_CNT_TC_EN
  assign tc = carry[NUM_DIGITS];
`else
  logic unused_all_nine;
  assign unused_all_nine = carry[NUM_DIGITS];
`endif

endmodule

// File: tb/tb_bcd_counter_top.sv
// Self-checking bench for bcd_counter_top against an integer-arithmetic reference count.
module tb_bcd_counter_top;

  localparam int unsigned ND  = 2;
  localparam int unsigned QW  = 4 * ND;
  localparam int          MOD = 100;

  logic          clk;
  logic          _rst;
  logic [QW-1:0] Q;
`ifdef BCD_CNT_TC_EN
  logic          tc;
`endif

  int n_cmp;
  int n_err;
  int model;

  bcd_counter_top #(.NUM_DIGITS(ND)) dut (
    .clk  (clk),
    ._rst (_rst),
    .Q    (Q)
`ifdef BCD_CNT_TC_EN
    ,
    .tc   (tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [QW-1:0] exp_q(input int c);
    logic [QW-1:0] e;
    int d;
    d = c;
    e = '0;
    for (int k = 0; k < ND; k++) begin
      e[4*k +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [QW-1:0] q_now;
    logic [3:0]    dig;
    q_now = Q;
    check(tag, 32'(q_now), 32'(exp_q(model)));
    for (int k = 0; k < ND; k++) begin
      dig = q_now[4*k +: 4];
      check({tag, "_digit_legal"}, 32'(dig <= 4'd9), 32'd1);
    end
`ifdef BCD_CNT_TC_EN
    check({tag, "_tc"}, 32'(tc), 32'(model == MOD - 1));
`endif
  endtask

  // Advance n posedges, checking the count at each following negedge.
  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!_rst) model = (model + 1) % MOD;
      @(negedge clk);
      check_state(tag);
    end
  endtask

  // Synchronous-style reset from a negedge: assert, hold over one posedge, release at negedge.
  task automatic do_reset();
    @(negedge clk);
    _rst = 1'b1;
    model = 0;
    #1;
    check_state("reset_assert");
    @(negedge clk);
    _rst = 1'b0;
  endtask

  initial begin
    int w;
    int off;
    n_cmp = 0;
    n_err = 0;
    model = 0;

    // Power-up reset: held 20 ns, released at a negedge.
    _rst = 1'b1;
    #1;
    check_state("por_q");
    #19;
    _rst = 1'b0;
    run(1, "first_after_release");
    run(9, "units_to_tens");

    // Full range and wrap.
    do_reset();
    run(98, "run_to_98");
    run(1, "reach_99");
    check("at_99", 32'(Q), 32'h99);
    run(1, "wrap_00");
    check("wrap_is_00", 32'(Q), 32'h00);

    // Short async pulse at 12, between clock edges.
    do_reset();
    run(12, "run_to_12");
    check("at_12", 32'(Q), 32'h12);
    #1;
    _rst = 1'b1;
    #1;
    model = 0;
    check_state("async_mid_cycle");
    #2;
    _rst = 1'b0;
    run(3, "resume_after_pulse");

    // Reset held across many edges.
    @(negedge clk);
    _rst = 1'b1;
    model = 0;
    run($urandom_range(5, 20), "held_reset");
    _rst = 1'b0;
    run(1, "release_after_hold");

    // 250 edges from reset.
    do_reset();
    run(250, "long_run");
    check("long_run_50", 32'(Q), 32'h50);

    // Random run lengths with random-width async pulses inside the low clock phase.
    for (int it = 0; it < 10; it++) begin
      run($urandom_range(1, 150), "rand_run");
      off = $urandom_range(1, 2);
      w   = $urandom_range(1, 2);
      #(off);
      _rst = 1'b1;
      model = 0;
      #(w);
      check_state("rand_pulse");
      _rst = 1'b0;
    end
    run(5, "rand_tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
